// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Fetch / decode / execute control sequencer for a small accumulator CPU.
// It fetches 12-bit instruction words from memory, keeps the program
// counter, and emits the load strobes that steer the datapath:
//   opcode 0x0-0xB  ALU op: accumulator and flags load together
//   opcode 0xC      JMP  imm
//   opcode 0xD      JZ   imm (taken when Z is set)
//   opcode 0xE      JC   imm (taken when C is set)
//   opcode 0xF      HALT (only reset leaves the halted state)
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-high reset
//   run          in   1   1 = keep sequencing, 0 = stop at next boundary
//   mem_ack      in   1   instruction memory data valid this cycle
//   mem_data     in  12   instruction word {opcode[3:0], imm[7:0]}
//   flags        in   4   {C, Z, N, OV}
//   mem_req      out  1   fetch request (FETCH state only)
//   address_bus  out  8   program counter
//   ir_load      out  1   instruction register capture strobe
//   acc_load     out  1   accumulator capture strobe
//   flag_load    out  1   flag register capture strobe
//   ir_out       out 12   current instruction
//   fde_out      out  3   one-hot phase {EXECUTE, DECODE, FETCH}
//   halted       out  1   high while halted
// ---------------------------------------------------------------------------
module instr_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mem_ack,
    input  logic [11:0] mem_data,
    input  logic [3:0]  flags,
    output logic        mem_req,
    output logic [7:0]  address_bus,
    output logic        ir_load,
    output logic        acc_load,
    output logic        flag_load,
    output logic [11:0] ir_out,
    output logic [2:0]  fde_out,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_LAST_ALU = 4'hB;
    localparam logic [3:0] OP_JMP      = 4'hC;
    localparam logic [3:0] OP_JZ       = 4'hD;
    localparam logic [3:0] OP_JC       = 4'hE;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_pc;
    logic [7:0]  w_pc_next;
    logic [11:0] r_ir;
    logic [11:0] w_ir_next;

    logic [3:0]  w_opcode;
    logic [7:0]  w_imm;
    logic        w_flag_c;
    logic        w_flag_z;
    logic        w_unused_flags;

    assign w_opcode       = r_ir[11:8];
    assign w_imm          = r_ir[7:0];
    assign w_flag_c       = flags[3];
    assign w_flag_z       = flags[2];
    // N and OV are carried on the bus but no branch here tests them.
    assign w_unused_flags = ^flags[1:0];

    assign address_bus = r_pc;
    assign ir_out      = r_ir;

    // State, program counter and instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= 8'h00;
            r_ir    <= 12'h000;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
        end
    end

    // Next-state, datapath updates and strobes.
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        mem_req      = 1'b0;
        ir_load      = 1'b0;
        acc_load     = 1'b0;
        flag_load    = 1'b0;
        fde_out      = 3'b000;
        halted       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req = 1'b1;
                fde_out = 3'b001;
                // Wait states simply hold here with PC on the bus.
                if (mem_ack) begin
                    ir_load      = 1'b1;
                    w_ir_next    = mem_data;
                    w_pc_next    = r_pc + 8'd1;  // wraps FF -> 00
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                fde_out      = 3'b010;
                w_next_state = S_EXECUTE;
            end

            S_EXECUTE: begin
                fde_out      = 3'b100;
                w_next_state = run ? S_FETCH : S_IDLE;
                if (w_opcode <= OP_LAST_ALU) begin
                    acc_load  = 1'b1;
                    flag_load = 1'b1;
                end else if (w_opcode == OP_JMP) begin
                    w_pc_next = w_imm;
                end else if (w_opcode == OP_JZ) begin
                    if (w_flag_z) begin
                        w_pc_next = w_imm;
                    end
                end else if (w_opcode == OP_JC) begin
                    if (w_flag_c) begin
                        w_pc_next = w_imm;
                    end
                end else begin
                    // 0xF: HALT overrides the run-based return.
                    w_next_state = S_HALT;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Bench for instr_sequencer. A small instruction memory answers fetches;
// the stimulus process loads a program, pushes the fetch addresses and the
// executed instructions it expects into queues, and a monitor pops and
// compares them whenever the sequencer fetches or executes.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        mem_ack;
    logic [11:0] mem_data;
    logic [3:0]  flags;
    logic        mem_req;
    logic [7:0]  address_bus;
    logic        ir_load;
    logic        acc_load;
    logic        flag_load;
    logic [11:0] ir_out;
    logic [2:0]  fde_out;
    logic        halted;

    typedef struct packed {
        logic [11:0] ir;
        logic        ld;
    } exec_t;

    logic [11:0] mem [256];
    logic [7:0]  fetch_q [$];
    exec_t       exec_q  [$];

    int vectors     = 0;
    int miscompares = 0;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .flags       (flags),
        .mem_req     (mem_req),
        .address_bus (address_bus),
        .ir_load     (ir_load),
        .acc_load    (acc_load),
        .flag_load   (flag_load),
        .ir_out      (ir_out),
        .fde_out     (fde_out),
        .halted      (halted)
    );

    assign mem_data = mem[address_bus];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
    endtask

    task automatic push_instr(input logic [7:0] addr, input logic [11:0] ir, input logic ld);
        exec_t e;
        fetch_q.push_back(addr);
        e.ir = ir;
        e.ld = ld;
        exec_q.push_back(e);
    endtask

    // Waits for the n-th cycle showing the given phase; returns at posedge+1.
    task automatic wait_fde(input logic [2:0] want, input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (fde_out == want) seen++;
            if (seen < n && cyc > 300) begin
                miscompares++;
                $display("FAIL wait_fde: phase %b seen %0d of %0d times", want, seen, n);
                return;
            end
        end
    endtask

    task automatic do_reset();
        check("queues_drained", fetch_q.size() + exec_q.size(), 0);
        fetch_q.delete();
        exec_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: fetch and execute events against the scoreboard, plus strobe invariants.
    always @(negedge clk) begin
        if (!rst) begin
            if (ir_load) begin
                if (fetch_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL fetch_unexpected: got addr %0h, expected no fetch", address_bus);
                end else begin
                    check("fetch_addr", address_bus, fetch_q.pop_front());
                end
            end
            if (fde_out == 3'b100) begin
                if (exec_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL exec_unexpected: got ir %0h, expected no execute", ir_out);
                end else begin
                    exec_t e;
                    e = exec_q.pop_front();
                    check("exec_ir", ir_out, e.ir);
                    check("exec_loads", {acc_load, flag_load}, {e.ld, e.ld});
                end
            end else if (acc_load || flag_load) begin
                miscompares++;
                $display("FAIL load_outside_exec: got acc/flag %b%b, expected 00", acc_load, flag_load);
            end
            if (acc_load != flag_load || (ir_load && acc_load)) begin
                miscompares++;
                $display("FAIL strobe_exclusive: got ir/acc/flag %b%b%b, expected one group", ir_load, acc_load, flag_load);
            end
            if (mem_req != (fde_out == 3'b001)) begin
                miscompares++;
                $display("FAIL mem_req_phase: got mem_req %b, expected %b", mem_req, fde_out == 3'b001);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst     = 1'b1;
        run     = 1'b0;
        mem_ack = 1'b1;
        flags   = 4'b0000;
        fill_mem();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_addr", address_bus, 8'h00);
        check("rst_ir", ir_out, 12'h000);
        check("rst_fde", fde_out, 3'b000);
        check("rst_halted", halted, 0);
        check("rst_loads", {ir_load, acc_load, flag_load}, 3'b000);

        // ALU op, JZ taken, JC not taken, jump-to-self loop.
        mem[8'h00] = 12'h305;
        mem[8'h01] = 12'hD40;
        mem[8'h40] = 12'hE20;
        mem[8'h41] = 12'hC41;
        flags      = 4'b0100;
        push_instr(8'h00, 12'h305, 1'b1);
        push_instr(8'h01, 12'hD40, 1'b0);
        push_instr(8'h40, 12'hE20, 1'b0);
        push_instr(8'h41, 12'hC41, 1'b0);
        push_instr(8'h41, 12'hC41, 1'b0);
        push_instr(8'h41, 12'hC41, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
        wait_fde(3'b100, 6);
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("loop_idle_fde", fde_out, 3'b000);
        check("loop_idle_pc", address_bus, 8'h41);

        // Wait states, run dropped in DECODE, resume, then HALT.
        fill_mem();
        mem[8'h00] = 12'h305;
        mem[8'h01] = 12'h1AB;
        flags      = 4'b0000;
        do_reset();
        mem_ack = 1'b0;
        run     = 1'b1;
        push_instr(8'h00, 12'h305, 1'b1);
        wait_fde(3'b001, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check("stall_fde", fde_out, 3'b001);
            check("stall_addr", address_bus, 8'h00);
            check("stall_no_irload", ir_load, 0);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        #1;
        check("stall_irload", ir_load, 1);
        @(posedge clk);
        #1;
        check("decode_fde", fde_out, 3'b010);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("exec_after_drop", fde_out, 3'b100);
        @(posedge clk);
        #1;
        check("drop_idle_fde", fde_out, 3'b000);
        check("drop_idle_req", mem_req, 0);
        check("drop_idle_pc", address_bus, 8'h01);
        push_instr(8'h01, 12'h1AB, 1'b1);
        push_instr(8'h02, 12'hF00, 1'b0);
        run = 1'b1;
        wait_fde(3'b100, 2);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("halt_halted", halted, 1);
            check("halt_req", mem_req, 0);
            check("halt_pc", address_bus, 8'h03);
            check("halt_fde", fde_out, 3'b000);
        end
        rst = 1'b1;
        #1;
        check("halt_rst_halted", halted, 0);
        check("halt_rst_pc", address_bus, 8'h00);
        check("halt_rst_ir", ir_out, 12'h000);

        // JZ not taken, JC taken to FF, wrap FF -> 00, reset mid-fetch.
        fill_mem();
        mem[8'h00] = 12'hD50;
        mem[8'h01] = 12'hEFF;
        mem[8'hFF] = 12'h012;
        flags      = 4'b1000;
        do_reset();
        mem_ack = 1'b1;
        run     = 1'b1;
        push_instr(8'h00, 12'hD50, 1'b0);
        push_instr(8'h01, 12'hEFF, 1'b0);
        push_instr(8'hFF, 12'h012, 1'b1);
        push_instr(8'h00, 12'hD50, 1'b0);
        wait_fde(3'b100, 4);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_idle_pc", address_bus, 8'h01);
        run = 1'b1;
        wait_fde(3'b001, 1);
        check("midfetch_irload_pre", ir_load, 1);
        rst = 1'b1;
        #1;
        check("midfetch_irload", ir_load, 0);
        check("midfetch_pc", address_bus, 8'h00);
        check("midfetch_ir", ir_out, 12'h000);
        check("midfetch_req", mem_req, 0);
        @(posedge clk);
        #1;
        push_instr(8'h00, 12'hD50, 1'b0);
        rst = 1'b0;
        wait_fde(3'b100, 1);
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_drained", fetch_q.size() + exec_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 run  in  1  level; 1 = sequence instructions, 0 = stop at next instruction boundary.
REQ-005 mem_ack  in  1  instruction memory valid; mem_data is sampled in the same cycle.
REQ-006 mem_data  in  12  instruction word: [11:8] opcode, [7:0] immediate.
REQ-007 flags  in  4  flag register contents {C,Z,N,OV}, bits [3:0] in that order.
REQ-008 mem_req  out  1  instruction fetch request.
REQ-009 address_bus  out  8  program counter (PC).
REQ-010 ir_load  out  1  one-cycle pulse: instruction register captures mem_data.
REQ-011 acc_load  out  1  one-cycle pulse: accumulator captures ALU result.
REQ-012 flag_load  out  1  one-cycle pulse: flag register captures ALU flags.
REQ-013 ir_out  out  12  latched current instruction.
REQ-014 fde_out  out  3  one-hot phase: [0] FETCH, [1] DECODE, [2] EXECUTE; 000 otherwise.
REQ-015 halted  out  1  high while in HALT state.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE, HALT.
REQ-017 IDLE: all pulses and mem_req low; move to FETCH on the first clock edge with run=1.
REQ-018 FETCH: mem_req=1, address_bus=PC; stay in FETCH while mem_ack=0.
REQ-019 FETCH with mem_ack=1: ir_load=1 in that cycle; on the edge ir_out<=mem_data, PC<=PC+1 mod 256 (FF->00), next state DECODE.
REQ-020 mem_req SHALL be low in every state except FETCH; mem_ack outside FETCH is ignored.
REQ-021 DECODE SHALL last exactly one cycle, then EXECUTE.
REQ-022 EXECUTE SHALL last exactly one cycle; action by ir_out[11:8]:
- 0x0-0xB (ALU ops): acc_load=1 and flag_load=1 for that cycle; PC unchanged.
- 0xC JMP: PC<=ir_out[7:0].
- 0xD JZ: PC<=ir_out[7:0] if flags Z=1, else unchanged.
- 0xE JC: PC<=ir_out[7:0] if flags C=1, else unchanged.
- 0xF HALT: next state HALT; no load pulses.
REQ-023 After a non-HALT EXECUTE, next state SHALL be FETCH if run=1, else IDLE.
REQ-024 run=0 during FETCH/DECODE SHALL NOT abort the instruction; it completes through EXECUTE.
REQ-025 HALT: halted=1, mem_req=0, fde_out=000, PC frozen; only rst exits HALT.
REQ-026 Minimum instruction latency SHALL be 3 cycles (FETCH with immediate ack, DECODE, EXECUTE); each extra mem_ack=0 cycle adds one.
REQ-027 At most one of ir_load, acc_load, flag_load-pair SHALL be active per cycle; acc_load and flag_load always coincide.
REQ-028 A jump to the address of the jump itself SHALL loop indefinitely without error.

Reset
REQ-029 On rst=1, immediately and independent of clk: state=IDLE, PC=00, ir_out=000, mem_req=0, all load pulses 0, fde_out=000, halted=0.
REQ-030 rst asserted mid-FETCH with mem_ack=1 SHALL suppress ir_load and the PC increment.
REQ-031 After rst deasserts, the first fetch SHALL use address 00.

Verification
REQ-032 Reset then run=1, mem_ack=1 every cycle, mem_data=0x305 -> mem_req at address 00, ir_load, DECODE, EXECUTE with acc_load=flag_load=1; PC=01 at next FETCH.
REQ-033 mem_ack held 0 for 4 FETCH cycles, then 1 -> mem_req high 5 cycles, address stable, single ir_load pulse.
REQ-034 JZ 0x40 with Z=1 -> next fetch at 40; same with Z=0 -> next fetch at PC+1; JC with C=1 -> next fetch at 0x40.
REQ-035 PC=FF fetching an ALU op -> next fetch at address 00.
REQ-036 HALT (0xF00) executed -> halted=1, mem_req=0 for 10+ cycles despite run=1; rst -> IDLE, halted=0, PC=00.
REQ-037 run dropped during DECODE -> EXECUTE completes, then IDLE with mem_req=0; run=1 resumes FETCH at the incremented PC.
